ten_gig_link_supervisor: RTL and testbench

TEN_GIG_LINK_SUPERVISOR -- requirements
Module: ten_gig_link_supervisor

---
 rtl/ten_gig_pkg.sv | 15 +
 rtl/ten_gig_link_sup_ch.sv | 147 ++++++++++++++
 rtl/ten_gig_link_supervisor.sv | 66 ++++++
 tb/tb_ten_gig_link_supervisor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ten_gig_pkg.sv
// Shared types and constants for the 10G link supervisor.
package ten_gig_pkg;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_RESET,
    ST_WAIT_DONE,
    ST_WAIT_LINK,
    ST_UP,
    ST_FAIL
  } state_t;

  localparam int DROP_W = 8;

endpackage

// File: rtl/ten_gig_link_sup_ch.sv
// Per-channel bring-up FSM: reset pulse, wait for reset-done, debounce the
// link qualifiers, watch the link while up and retry or give up on failure.
module ten_gig_link_sup_ch
  import ten_gig_pkg::*;
#(
  parameter int RESET_HOLD = 16,
  parameter int DEBOUNCE   = 1024,
  parameter int TIMEOUT    = 1000000,
  parameter int MAX_RETRY  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              rst_done,
  input  logic              block_sync,
  input  logic              pma_link,
  input  logic              pcs_rx_link,
  output logic              ch_rst,
  output logic              link_up,
  output logic              link_fail,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int HOLD_W = $clog2(RESET_HOLD + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_HOLD - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE - 1);
  localparam logic [3:0]        RETRY_LAST = 4'(MAX_RETRY);

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
  logic [DEB_W-1:0]    deb_cnt, deb_nxt;
  logic [3:0]          retry_cnt, retry_nxt;
  logic [DROP_W-1:0]   drop_q, drop_nxt;
  logic                qual_ok;
  logic                attempt_fail;

  // Saturating increment for the link-drop counter.
  function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign qual_ok  = block_sync & pma_link & pcs_rx_link;
  assign drop_cnt = drop_q;

  // State and counter registers; reset returns everything to an idle OFF channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      hold_cnt  <= '0;
      tmo_cnt   <= '0;
      deb_cnt   <= '0;
      retry_cnt <= '0;
      drop_q    <= '0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      tmo_cnt   <= tmo_nxt;
      deb_cnt   <= deb_nxt;
      retry_cnt <= retry_nxt;
      drop_q    <= drop_nxt;
    end
  end

  // Next-state, counter updates and Moore outputs.
  always_comb begin
    state_nxt    = state;
    hold_nxt     = hold_cnt;
    tmo_nxt      = tmo_cnt;
    deb_nxt      = deb_cnt;
    retry_nxt    = retry_cnt;
    drop_nxt     = drop_q;
    attempt_fail = 1'b0;
    ch_rst       = 1'b0;
    link_up      = 1'b0;
    link_fail    = 1'b0;

    case (state)
      ST_OFF: begin
        ch_rst = 1'b1;
        if (enable) state_nxt = ST_RESET;
      end
      ST_RESET: begin
        ch_rst = 1'b1;
        if (hold_cnt == HOLD_LAST) state_nxt = ST_WAIT_DONE;
        else                       hold_nxt  = hold_cnt + HOLD_W'(1);
      end
      ST_WAIT_DONE: begin
        if (rst_done)                state_nxt    = ST_WAIT_LINK;
        else if (tmo_cnt == TMO_LAST) attempt_fail = 1'b1;
        else                         tmo_nxt      = tmo_cnt + TMO_W'(1);
      end
      ST_WAIT_LINK: begin
        // Any qualifier dropout restarts the debounce window.
        deb_nxt = qual_ok ? deb_cnt + DEB_W'(1) : '0;
        if (qual_ok && deb_cnt == DEB_LAST) state_nxt    = ST_UP;
        else if (tmo_cnt == TMO_LAST)       attempt_fail = 1'b1;
        else                                tmo_nxt      = tmo_cnt + TMO_W'(1);
      end
      ST_UP: begin
        link_up   = 1'b1;
        retry_nxt = '0;
        if (!(qual_ok && rst_done)) begin
          drop_nxt  = drop_sat_inc(drop_q);
          state_nxt = ST_RESET;
        end
      end
      ST_FAIL: begin
        ch_rst    = 1'b1;
        link_fail = 1'b1;
        if (clear) state_nxt = ST_RESET;
      end
      default: state_nxt = ST_OFF;
    endcase

    if (attempt_fail) begin
      retry_nxt = retry_cnt + 4'd1;
      state_nxt = (retry_nxt == RETRY_LAST) ? ST_FAIL : ST_RESET;
    end

    // Clear wins over a simultaneous drop increment; it also releases FAIL.
    if (clear) begin
      retry_nxt = '0;
      drop_nxt  = '0;
      if (state_nxt == ST_FAIL) state_nxt = ST_RESET;
    end

    // Disable overrides every other transition and never counts a drop.
    if (!enable) begin
      state_nxt = ST_OFF;
      retry_nxt = '0;
      drop_nxt  = clear ? '0 : drop_q;
    end

    if (state_nxt != state) begin
      hold_nxt = '0;
      tmo_nxt  = '0;
      deb_nxt  = '0;
    end
  end

endmodule

// File: rtl/ten_gig_link_supervisor.sv
// Supervises NUM_CH 10G PCS/PMA channels: synchronizes the asynchronous
// status inputs and runs one independent bring-up FSM per channel.
module ten_gig_link_supervisor
  import ten_gig_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int RESET_HOLD = 16,
  parameter int DEBOUNCE   = 1024,
  parameter int TIMEOUT    = 1000000,
  parameter int MAX_RETRY  = 3
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_ch_enable,
  input  logic                     i_clear,
  input  logic [NUM_CH-1:0]        i_rst_done,
  input  logic [NUM_CH-1:0]        i_block_sync,
  input  logic [NUM_CH-1:0]        i_pma_link,
  input  logic [NUM_CH-1:0]        i_pcs_rx_link,
  output logic [NUM_CH-1:0]        o_ch_rst,
  output logic [NUM_CH-1:0]        o_link_up,
  output logic [NUM_CH-1:0]        o_link_fail,
  output logic [DROP_W*NUM_CH-1:0] o_drop_cnt
);

  localparam int SW = 4 * NUM_CH;

  logic [SW-1:0] async_in;
  logic [SW-1:0] sync_p0, sync_p1;

  assign async_in = {i_pcs_rx_link, i_pma_link, i_block_sync, i_rst_done};

  // Two-flop synchronizer for all asynchronous status inputs.
  always_ff @(posedge i_sys_clk) begin
    if (i_rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    ten_gig_link_sup_ch #(
      .RESET_HOLD (RESET_HOLD),
      .DEBOUNCE   (DEBOUNCE),
      .TIMEOUT    (TIMEOUT),
      .MAX_RETRY  (MAX_RETRY)
    ) u_ch (
      .clk         (i_sys_clk),
      .rst         (i_rst),
      .enable      (i_ch_enable[n]),
      .clear       (i_clear),
      .rst_done    (sync_p1[n]),
      .block_sync  (sync_p1[NUM_CH + n]),
      .pma_link    (sync_p1[2*NUM_CH + n]),
      .pcs_rx_link (sync_p1[3*NUM_CH + n]),
      .ch_rst      (o_ch_rst[n]),
      .link_up     (o_link_up[n]),
      .link_fail   (o_link_fail[n]),
      .drop_cnt    (o_drop_cnt[DROP_W*n +: DROP_W])
    );
  end

endmodule

// File: tb/tb_ten_gig_link_supervisor.sv
// Directed bench for ten_gig_link_supervisor (NUM_CH=2, RESET_HOLD=4,
// DEBOUNCE=8, TIMEOUT=64, MAX_RETRY=3).
module tb_ten_gig_link_supervisor;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en;
  logic        clr;
  logic [1:0]  rd;
  logic [1:0]  bs;
  logic [1:0]  pma;
  logic [1:0]  pcs;
  logic [1:0]  ch_rst;
  logic [1:0]  link_up;
  logic [1:0]  link_fail;
  logic [15:0] drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ten_gig_link_supervisor #(
    .NUM_CH     (2),
    .RESET_HOLD (4),
    .DEBOUNCE   (8),
    .TIMEOUT    (64),
    .MAX_RETRY  (3)
  ) dut (
    .i_sys_clk     (clk),
    .i_rst         (rst),
    .i_ch_enable   (en),
    .i_clear       (clr),
    .i_rst_done    (rd),
    .i_block_sync  (bs),
    .i_pma_link    (pma),
    .i_pcs_rx_link (pcs),
    .o_ch_rst      (ch_rst),
    .o_link_up     (link_up),
    .o_link_fail   (link_fail),
    .o_drop_cnt    (drop)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the DUT just out of reset; the caller drives inputs for the next edge.
  task automatic do_reset();
    rst = 1'b1; en = 2'b00; clr = 1'b0;
    rd = 2'b00; bs = 2'b00; pma = 2'b00; pcs = 2'b00;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 2'b11; clr = 1'b0;
    rd = 2'b11; bs = 2'b11; pma = 2'b11; pcs = 2'b11;
    tick(3);
    n_cmp++; if (ch_rst !== 2'b11) begin n_bad++; $display("FAIL reset_ch_rst got=%b exp=11", ch_rst); end
    n_cmp++; if (link_up !== 2'b00) begin n_bad++; $display("FAIL reset_link_up got=%b exp=00", link_up); end
    n_cmp++; if (link_fail !== 2'b00) begin n_bad++; $display("FAIL reset_link_fail got=%b exp=00", link_fail); end
    n_cmp++; if (drop !== 16'h0000) begin n_bad++; $display("FAIL reset_drop got=%h exp=0000", drop); end
  endtask

  task automatic test_bringup();
    int cnt;
    do_reset();
    en = 2'b01; rd = 2'b01; bs = 2'b01; pma = 2'b01; pcs = 2'b01;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ch_rst[0]) cnt++;
      else break;
    end
    n_cmp++; if (cnt !== 4) begin n_bad++; $display("FAIL bringup_rst_hold got=%0d exp=4", cnt); end
    tick(8);
    n_cmp++; if (link_up[0] !== 1'b0) begin n_bad++; $display("FAIL bringup_early_up got=%b exp=0", link_up[0]); end
    tick(1);
    n_cmp++; if (link_up[0] !== 1'b1) begin n_bad++; $display("FAIL bringup_up got=%b exp=1", link_up[0]); end
    n_cmp++; if (ch_rst !== 2'b10) begin n_bad++; $display("FAIL bringup_ch1_off got=%b exp=10", ch_rst); end
    n_cmp++; if (link_up[1] !== 1'b0) begin n_bad++; $display("FAIL bringup_ch1_up got=%b exp=0", link_up[1]); end
  endtask

  task automatic test_debounce();
    do_reset();
    en = 2'b01; rd = 2'b01; bs = 2'b01; pma = 2'b01; pcs = 2'b00;
    tick(6);
    n_cmp++; if (ch_rst[0] !== 1'b0) begin n_bad++; $display("FAIL deb_wait_link_rst got=%b exp=0", ch_rst[0]); end
    pcs = 2'b01;
    tick(7);
    pcs = 2'b00;
    tick(1);
    pcs = 2'b01;
    tick(2);
    n_cmp++; if (link_up[0] !== 1'b0) begin n_bad++; $display("FAIL deb_glitch_up got=%b exp=0", link_up[0]); end
    tick(7);
    n_cmp++; if (link_up[0] !== 1'b0) begin n_bad++; $display("FAIL deb_restart_early got=%b exp=0", link_up[0]); end
    tick(1);
    n_cmp++; if (link_up[0] !== 1'b1) begin n_bad++; $display("FAIL deb_restart_up got=%b exp=1", link_up[0]); end
  endtask

  task automatic test_timeout_fail();
    do_reset();
    en = 2'b11; rd = 2'b01; bs = 2'b01; pma = 2'b01; pcs = 2'b01;
    tick(68);
    n_cmp++; if (ch_rst[1] !== 1'b0) begin n_bad++; $display("FAIL tmo_wait_done got=%b exp=0", ch_rst[1]); end
    tick(1);
    n_cmp++; if (ch_rst[1] !== 1'b1) begin n_bad++; $display("FAIL tmo_retry_rst got=%b exp=1", ch_rst[1]); end
    tick(135);
    n_cmp++; if (link_fail[1] !== 1'b0) begin n_bad++; $display("FAIL tmo_early_fail got=%b exp=0", link_fail[1]); end
    tick(1);
    n_cmp++; if (link_fail !== 2'b10) begin n_bad++; $display("FAIL tmo_fail_flag got=%b exp=10", link_fail); end
    n_cmp++; if (ch_rst[1] !== 1'b1) begin n_bad++; $display("FAIL tmo_fail_rst got=%b exp=1", ch_rst[1]); end
    n_cmp++; if (link_up[0] !== 1'b1) begin n_bad++; $display("FAIL tmo_ch0_up got=%b exp=1", link_up[0]); end
    tick(10);
    n_cmp++; if (link_fail[1] !== 1'b1) begin n_bad++; $display("FAIL tmo_fail_sticky got=%b exp=1", link_fail[1]); end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    n_cmp++; if (link_fail[1] !== 1'b0) begin n_bad++; $display("FAIL tmo_clear_flag got=%b exp=0", link_fail[1]); end
    n_cmp++; if (ch_rst[1] !== 1'b1) begin n_bad++; $display("FAIL tmo_clear_rst got=%b exp=1", ch_rst[1]); end
    tick(4);
    n_cmp++; if (ch_rst[1] !== 1'b0) begin n_bad++; $display("FAIL tmo_clear_reattempt got=%b exp=0", ch_rst[1]); end
    n_cmp++; if (drop !== 16'h0000) begin n_bad++; $display("FAIL tmo_no_drop got=%h exp=0000", drop); end
  endtask

  task automatic test_drop_saturate();
    bit ok;
    do_reset();
    en = 2'b01; rd = 2'b01; bs = 2'b01; pma = 2'b01; pcs = 2'b01;
    tick(14);
    n_cmp++; if (link_up[0] !== 1'b1) begin n_bad++; $display("FAIL drop_initial_up got=%b exp=1", link_up[0]); end
    ok = 1'b1;
    for (int d = 1; d <= 300 && ok; d++) begin
      bs = 2'b00;
      tick(1);
      bs = 2'b01;
      tick(2);
      for (int w = 0; w < 40 && !link_up[0]; w++) tick(1);
      if (!link_up[0]) begin
        ok = 1'b0;
        n_cmp++; n_bad++;
        $display("FAIL drop_relink_timeout drop_no=%0d link_up=%b exp=1", d, link_up[0]);
      end
      if (d == 10) begin
        n_cmp++; if (drop[7:0] !== 8'd10) begin n_bad++; $display("FAIL drop_count10 got=%0d exp=10", drop[7:0]); end
      end
    end
    n_cmp++; if (drop[7:0] !== 8'd255) begin n_bad++; $display("FAIL drop_saturate got=%0d exp=255", drop[7:0]); end
    n_cmp++; if (drop[15:8] !== 8'd0) begin n_bad++; $display("FAIL drop_ch1 got=%0d exp=0", drop[15:8]); end
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    n_cmp++; if (drop[7:0] !== 8'd0) begin n_bad++; $display("FAIL drop_clear got=%0d exp=0", drop[7:0]); end
    // Clear on the very edge the drop is taken: count stays 0, link still drops.
    bs = 2'b00;
    tick(1);
    bs = 2'b01;
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    n_cmp++; if (drop[7:0] !== 8'd0) begin n_bad++; $display("FAIL drop_clear_coincide got=%0d exp=0", drop[7:0]); end
    n_cmp++; if (link_up[0] !== 1'b0) begin n_bad++; $display("FAIL drop_coincide_down got=%b exp=0", link_up[0]); end
    n_cmp++; if (ch_rst[0] !== 1'b1) begin n_bad++; $display("FAIL drop_coincide_rst got=%b exp=1", ch_rst[0]); end
  endtask

  task automatic test_abort();
    do_reset();
    en = 2'b01; rd = 2'b01; bs = 2'b01; pma = 2'b01; pcs = 2'b01;
    tick(10);
    rst = 1'b1;
    tick(1);
    n_cmp++; if (ch_rst !== 2'b11) begin n_bad++; $display("FAIL abort_rst_ch_rst got=%b exp=11", ch_rst); end
    n_cmp++; if (link_up !== 2'b00) begin n_bad++; $display("FAIL abort_rst_up got=%b exp=00", link_up); end
    n_cmp++; if (drop !== 16'h0000) begin n_bad++; $display("FAIL abort_rst_drop got=%h exp=0000", drop); end
    rst = 1'b0;
    tick(13);
    n_cmp++; if (link_up[0] !== 1'b0) begin n_bad++; $display("FAIL abort_residual_up got=%b exp=0", link_up[0]); end
    tick(1);
    n_cmp++; if (link_up[0] !== 1'b1) begin n_bad++; $display("FAIL abort_reup got=%b exp=1", link_up[0]); end
    do_reset();
    en = 2'b01; rd = 2'b01; bs = 2'b01; pma = 2'b01; pcs = 2'b01;
    tick(2);
    en = 2'b00;
    tick(1);
    n_cmp++; if (ch_rst[0] !== 1'b1) begin n_bad++; $display("FAIL dis_ch_rst got=%b exp=1", ch_rst[0]); end
    tick(8);
    n_cmp++; if (ch_rst[0] !== 1'b1) begin n_bad++; $display("FAIL dis_stays_off got=%b exp=1", ch_rst[0]); end
    n_cmp++; if (link_up[0] !== 1'b0) begin n_bad++; $display("FAIL dis_up got=%b exp=0", link_up[0]); end
    n_cmp++; if (drop !== 16'h0000) begin n_bad++; $display("FAIL dis_drop got=%h exp=0000", drop); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_debounce();
    test_timeout_fail();
    test_drop_saturate();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
